can_tx_scheduler: RTL and testbench
===================================

// Module: can_tx_scheduler
// PURPOSE
// Multi-mailbox transmit scheduler in front of tx_container. Holds NUM_MB pending CAN
// frames (11-bit ID, 32-bit data) and always offers the lowest ID first (CAN priority).
// Sequences the transmitter's address/data/send_data inputs and retries on arbitration loss.
// Reports per-mailbox completion or failure, so several requesters share one CAN transmitter.
// PARAMETERS
// NUM_MB     4     number of mailboxes (2..8)
// SEND_HOLD  1024  clk cycles send_data is held high; must exceed one baud_clk period
// MAX_RETRY  8     arbitration-loss retries per frame before mb_error
// TIMEOUT    65535 clk cycles in WAIT with no tx_done/tx_arb_lost before mb_error
// PORTS
// clk          in   1          system clock; all logic on rising edge
// rst          in   1          synchronous, active-low reset (0 = reset)
// mb_load      in   NUM_MB     1-cycle pulse: load mailbox i from mb_id/mb_data slice i
// mb_id        in   11*NUM_MB  frame ID per mailbox, slice i = [11*i+10:11*i]
// mb_data      in   32*NUM_MB  frame payload per mailbox, slice i = [32*i+31:32*i]
// mb_pending   out  NUM_MB     mailbox i holds an unsent frame
// mb_done      out  NUM_MB     1-cycle pulse: mailbox i frame sent successfully
// mb_error     out  NUM_MB     1-cycle pulse: mailbox i dropped (retry limit or timeout)
// address      out  11         to tx_container address
// data         out  32         to tx_container data
// send_data    out  1          to tx_container send_data
// tx_done      in   1          1-cycle pulse from transmitter: frame completed
// tx_arb_lost  in   1          1-cycle pulse from transmitter: arbitration lost
// BEHAVIOUR
// - Reset (rst=0 at an edge): FSM=IDLE; all mailboxes cleared; retry and timer counters = 0.
//   All outputs are 0 after that edge. Applies even mid-frame: send_data drops, no done/error pulse.
// - Load: mb_load[i] at edge n sets mb_pending[i]=1 and stores ID/data after edge n.
//   A load to a non-active pending mailbox overwrites it. A load to the active mailbox
//   (SELECT..WAIT) is ignored. Simultaneous loads to several mailboxes are all accepted.
// - FSM states: IDLE, SELECT, START, WAIT.
// - IDLE: if any mb_pending -> SELECT next edge.
// - SELECT (1 cycle): active = pending mailbox with lowest ID; ties go to the lowest index.
//   address/data are registered from the active mailbox. Retry count resets if active differs
//   from the previous active mailbox. -> START.
// - START: send_data=1 for exactly SEND_HOLD cycles, then send_data=0 -> WAIT.
//   address/data stay stable from SELECT until the WAIT exit.
// - WAIT: tx_done -> clear pending[active], pulse mb_done[active], -> IDLE.
//   tx_arb_lost -> retry+1. If retry < MAX_RETRY -> SELECT (priorities re-evaluated, so a newly
//   loaded lower ID may pre-empt). Otherwise clear pending, pulse mb_error, -> IDLE.
//   Timer reaches TIMEOUT -> clear pending, pulse mb_error, -> IDLE.
//   tx_done and tx_arb_lost in the same cycle: tx_done wins.
// - tx_done/tx_arb_lost outside WAIT are ignored.
// - Latency: mb_load edge n into idle FSM -> SELECT after edge n+1.
//   address/data valid after edge n+2; send_data high after edge n+3.
// - Only one of mb_done/mb_error is high in any cycle, with at most one bit set.
// TESTING
// 1 Reset: rst=0 for 4 cycles with mb_load active -> all outputs 0, mb_pending=0.
// 2 Single frame: load mb0 ID=11'h028, data=32'hAAAAAAAA -> address=11'h028, data=AAAAAAAA.
//   send_data high for exactly 1024 cycles; tx_done then pulses mb_done=4'b0001, pending cleared.
// 3 Priority: load mb0 ID=11'h100, mb2 ID=11'h028, and mb3 ID=11'h028 in the same cycle
//   -> order sent is mb2, mb3, mb0; mb_done pulses in that order.
// 4 Pre-emption: during WAIT for ID 11'h100, load mb1 ID=11'h005, then pulse tx_arb_lost
//   -> next SELECT picks 11'h005.
// 5 Retry limit: answer every attempt with tx_arb_lost -> 8 retries, then mb_error pulse.
//   Exactly 9 send_data pulses in total.
// 6 Timeout/reset: no tx response -> mb_error after 65535 WAIT cycles.
//   Separately, rst=0 mid-START -> send_data=0 next cycle, no done/error pulse.

Source files
------------

// File: rtl/can_tx_scheduler_if.sv
// can_tx_scheduler_if: requester/transmitter signals of the multi-mailbox CAN transmit scheduler.
interface can_tx_scheduler_if #(parameter int NUM_MB = 4);
    logic [NUM_MB-1:0]    mb_load;
    logic [11*NUM_MB-1:0] mb_id;
    logic [32*NUM_MB-1:0] mb_data;
    logic [NUM_MB-1:0]    mb_pending;
    logic [NUM_MB-1:0]    mb_done;
    logic [NUM_MB-1:0]    mb_error;
    logic [10:0]          address;
    logic [31:0]          data;
    logic                 send_data;
    logic                 tx_done;
    logic                 tx_arb_lost;
    modport master (
        output mb_load, mb_id, mb_data, tx_done, tx_arb_lost,
        input  mb_pending, mb_done, mb_error, address, data, send_data
    );
    modport slave (
        input  mb_load, mb_id, mb_data, tx_done, tx_arb_lost,
        output mb_pending, mb_done, mb_error, address, data, send_data
    );
endinterface

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: holds NUM_MB pending CAN frames, feeds the lowest ID to tx_container,
// retries on arbitration loss and reports per-mailbox done/error pulses.
module can_tx_scheduler #(
    parameter int NUM_MB    = 4,
    parameter int SEND_HOLD = 1024,
    parameter int MAX_RETRY = 8,
    parameter int TIMEOUT   = 65535
) (
    input  logic               clk,
    input  logic               rst,
    can_tx_scheduler_if.slave  bus
);
    localparam int IW = $clog2(NUM_MB);
    localparam int CW = $clog2(SEND_HOLD + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, SELECT, START, WAIT} state_t;
    state_t            state_q;
    logic [NUM_MB-1:0] pend_q, done_q, err_q;
    logic [10:0]       id_q  [NUM_MB];
    logic [31:0]       pay_q [NUM_MB];
    logic [IW-1:0]     act_q, sel_d, busy_d;
    logic [10:0]       best_d, addr_q;
    logic [31:0]       dat_q;
    logic              found_d, send_q;
    logic [CW-1:0]     hold_q;
    logic [RW-1:0]     retry_q;
    logic [TW-1:0]     timer_q;
    // strict '<' keeps the lowest index on equal IDs
    always_comb begin
        sel_d   = '0;
        best_d  = '1;
        found_d = 1'b0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (pend_q[i] && (!found_d || id_q[i] < best_d)) begin
                sel_d   = IW'(i);
                best_d  = id_q[i];
                found_d = 1'b1;
            end
        end
        busy_d = (state_q == SELECT) ? sel_d : act_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            done_q  <= '0;
            err_q   <= '0;
            act_q   <= '0;
            addr_q  <= '0;
            dat_q   <= '0;
            send_q  <= 1'b0;
            hold_q  <= '0;
            retry_q <= '0;
            timer_q <= '0;
            for (int i = 0; i < NUM_MB; i++) begin
                id_q[i]  <= '0;
                pay_q[i] <= '0;
            end
        end else begin
            done_q <= '0;
            err_q  <= '0;
            for (int i = 0; i < NUM_MB; i++) begin
                if (bus.mb_load[i] && !(state_q != IDLE && busy_d == IW'(i))) begin
                    pend_q[i] <= 1'b1;
                    id_q[i]   <= bus.mb_id[11*i +: 11];
                    pay_q[i]  <= bus.mb_data[32*i +: 32];
                end
            end
            case (state_q)
                IDLE: if (|pend_q) state_q <= SELECT;
                SELECT: begin
                    act_q   <= sel_d;
                    addr_q  <= id_q[sel_d];
                    dat_q   <= pay_q[sel_d];
                    hold_q  <= '0;
                    state_q <= START;
                    if (sel_d != act_q) retry_q <= '0;
                end
                START: begin
                    if (hold_q == CW'(SEND_HOLD)) begin
                        send_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= WAIT;
                    end else begin
                        send_q <= 1'b1;
                        hold_q <= hold_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        pend_q[act_q] <= 1'b0;
                        done_q[act_q] <= 1'b1;
                        retry_q       <= '0;
                        state_q       <= IDLE;
                    end else if (bus.tx_arb_lost && retry_q < RW'(MAX_RETRY)) begin
                        retry_q <= retry_q + 1'b1;
                        state_q <= SELECT;
                    end else if (bus.tx_arb_lost || timer_q == TW'(TIMEOUT - 1)) begin
                        pend_q[act_q] <= 1'b0;
                        err_q[act_q]  <= 1'b1;
                        retry_q       <= '0;
                        state_q       <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.mb_pending = pend_q;
    assign bus.mb_done    = done_q;
    assign bus.mb_error   = err_q;
    assign bus.address    = addr_q;
    assign bus.data       = dat_q;
    assign bus.send_data  = send_q;
endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb_can_tx_scheduler: scoreboard bench; expected attempts/results are queued when stimulus is driven.
module tb_can_tx_scheduler;
    typedef struct {logic [10:0] a; logic [31:0] d;} att_t;
    typedef struct {logic [3:0] done; logic [3:0] err;} res_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    int   hi_len = 0;
    logic prev_send = 1'b0;
    att_t exp_att[$];
    res_t exp_res[$];
    can_tx_scheduler_if #(.NUM_MB(4)) bus();
    can_tx_scheduler #(.NUM_MB(4), .SEND_HOLD(1024), .MAX_RETRY(8), .TIMEOUT(65535)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        att_t a;
        res_t r;
        if (bus.send_data && !prev_send) begin
            hi_len = 1;
            if (exp_att.size() == 0) chk("attempt_unexpected", 1, 0);
            else begin
                a = exp_att.pop_front();
                chk("address", 64'(bus.address), 64'(a.a));
                chk("data", 64'(bus.data), 64'(a.d));
            end
        end else if (bus.send_data) hi_len++;
        if (!bus.send_data && prev_send && rst) begin
            chk("hold_len", 64'(hi_len), 64'd1024);
            pulses++;
        end
        prev_send = bus.send_data;
        if (|{bus.mb_done, bus.mb_error}) begin
            chk("onehot", 64'($countones({bus.mb_done, bus.mb_error})), 64'd1);
            if (exp_res.size() == 0) chk("result_unexpected", {bus.mb_done, bus.mb_error}, 0);
            else begin
                r = exp_res.pop_front();
                chk("mb_done", 64'(bus.mb_done), 64'(r.done));
                chk("mb_error", 64'(bus.mb_error), 64'(r.err));
            end
        end
    end
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic set_mb(input int i, input logic [10:0] id, input logic [31:0] d);
        bus.mb_id[11*i +: 11]  = id;
        bus.mb_data[32*i +: 32] = d;
    endtask
    task automatic pulse_load(input logic [3:0] m);
        bus.mb_load = m;
        tick(1);
        bus.mb_load = '0;
    endtask
    task automatic wait_fall();
        int n = 0;
        while (!bus.send_data && n < 100) begin tick(1); n++; end
        while (bus.send_data && n < 2000) begin tick(1); n++; end
        if (n >= 2000 || n < 2) chk("wait_fall_timeout", 64'(n), 64'd1100);
    endtask
    task automatic respond(input logic done, input logic lost);
        bus.tx_done     = done;
        bus.tx_arb_lost = lost;
        tick(1);
        bus.tx_done     = 1'b0;
        bus.tx_arb_lost = 1'b0;
    endtask
    task automatic push(input logic [10:0] a, input logic [31:0] d);
        exp_att.push_back('{a: a, d: d});
    endtask
    task automatic push_res(input logic [3:0] done, input logic [3:0] err);
        exp_res.push_back('{done: done, err: err});
    endtask
    initial begin
        int n;
        int p0;
        bus.mb_load = '0;
        bus.mb_id = '0;
        bus.mb_data = '0;
        bus.tx_done = 1'b0;
        bus.tx_arb_lost = 1'b0;
        // 1: reset with loads active
        for (int i = 0; i < 4; i++) set_mb(i, 11'h10 + 11'(i), 32'hC0DE0000 + i);
        bus.mb_load = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_outputs", {bus.mb_pending, bus.mb_done, bus.mb_error, bus.send_data, bus.address, bus.data}, 0);
        end
        bus.mb_load = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(3);
        chk("pending_after_reset", 64'(bus.mb_pending), 0);
        // 2: single frame and latency
        set_mb(0, 11'h028, 32'hAAAAAAAA);
        push(11'h028, 32'hAAAAAAAA);
        push_res(4'b0001, 4'b0000);
        pulse_load(4'b0001);
        chk("pending_set", 64'(bus.mb_pending), 64'h1);
        tick(2);
        chk("lat_address", 64'(bus.address), 64'h028);
        chk("lat_data", 64'(bus.data), 64'hAAAAAAAA);
        chk("lat_send_low", 64'(bus.send_data), 0);
        tick(1);
        chk("lat_send_high", 64'(bus.send_data), 1);
        wait_fall();
        set_mb(0, 11'h7FF, 32'h55555555);
        pulse_load(4'b0001);
        chk("active_load_addr", 64'(bus.address), 64'h028);
        respond(1'b1, 1'b0);
        tick(1);
        chk("pending_cleared", 64'(bus.mb_pending), 0);
        tick(3);
        // 3: priority order, final tx_done and tx_arb_lost together
        set_mb(0, 11'h100, 32'h00000000);
        set_mb(2, 11'h028, 32'h22222222);
        set_mb(3, 11'h028, 32'h33333333);
        push(11'h028, 32'h22222222);
        push(11'h028, 32'h33333333);
        push(11'h100, 32'h00000000);
        push_res(4'b0100, 4'b0000);
        push_res(4'b1000, 4'b0000);
        push_res(4'b0001, 4'b0000);
        pulse_load(4'b1101);
        chk("pending_multi", 64'(bus.mb_pending), 64'hD);
        wait_fall();
        respond(1'b1, 1'b0);
        wait_fall();
        respond(1'b1, 1'b0);
        wait_fall();
        respond(1'b1, 1'b1);
        tick(3);
        chk("pending_after_prio", 64'(bus.mb_pending), 0);
        // 4: pre-emption by a newly loaded lower ID
        set_mb(0, 11'h100, 32'hB0B0B0B0);
        set_mb(1, 11'h005, 32'h05050505);
        push(11'h100, 32'hB0B0B0B0);
        push(11'h005, 32'h05050505);
        push(11'h100, 32'hB0B0B0B0);
        push_res(4'b0010, 4'b0000);
        push_res(4'b0001, 4'b0000);
        pulse_load(4'b0001);
        wait_fall();
        pulse_load(4'b0010);
        respond(1'b0, 1'b1);
        wait_fall();
        respond(1'b1, 1'b0);
        wait_fall();
        respond(1'b1, 1'b0);
        tick(3);
        // 5: retry limit
        set_mb(0, 11'h055, 32'h12345678);
        for (int i = 0; i < 9; i++) push(11'h055, 32'h12345678);
        push_res(4'b0000, 4'b0001);
        p0 = pulses;
        pulse_load(4'b0001);
        for (int i = 0; i < 9; i++) begin
            wait_fall();
            respond(1'b0, 1'b1);
        end
        tick(3);
        chk("retry_pulses", 64'(pulses - p0), 64'd9);
        chk("pending_after_retry", 64'(bus.mb_pending), 0);
        // 6: timeout, then reset in the middle of START
        set_mb(2, 11'h3AB, 32'hDEADBEEF);
        push(11'h3AB, 32'hDEADBEEF);
        push_res(4'b0000, 4'b0100);
        pulse_load(4'b0100);
        wait_fall();
        n = 0;
        while (!bus.mb_error[2] && n < 70000) begin tick(1); n++; end
        chk("timeout_cycles", 64'(n), 64'd65535);
        tick(3);
        set_mb(1, 11'h077, 32'h77777777);
        push(11'h077, 32'h77777777);
        pulse_load(4'b0010);
        n = 0;
        while (!bus.send_data && n < 100) begin tick(1); n++; end
        tick(10);
        rst = 1'b0;
        tick(1);
        chk("rst_mid_send", 64'(bus.send_data), 0);
        chk("rst_mid_pending", 64'(bus.mb_pending), 0);
        tick(3);
        rst = 1'b1;
        tick(20);
        chk("att_queue_empty", 64'(exp_att.size()), 0);
        chk("res_queue_empty", 64'(exp_res.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
